chip8_mem_arbiter: RTL and testbench

Shares the single-port 4 KB x 8 CHIP-8 RAM among three requesters: ROM loader, CPU and display scanout/sprite engine.
- Grants at most one access per cycle and drives the RAM port.
- Returns read data with a fixed 1-cycle latency and a per-requester valid strobe.
- Sits between chip8_cpu's mem_* interface and the RAM. A CPU lock lets the two-byte instruction fetch complete back-to-back.

---
 rtl/chip8_pkg.sv | 18 +
 rtl/chip8_rr_pick2.sv | 15 +
 rtl/chip8_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared constants and enums for the CHIP-8 memory subsystem.
package chip8_pkg;

    localparam int CHIP8_ADDR_W = 12;
    localparam int CHIP8_DATA_W = 8;

    typedef enum logic [1:0] {
        REQ_LD  = 2'd0,
        REQ_CPU = 2'd1,
        REQ_VID = 2'd2
    } req_idx_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/chip8_rr_pick2.sv
// Two-way round-robin picker; force_b lets requester b win outright.
module chip8_rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic force_b,
    input  logic last_b,
    output logic gnt_a,
    output logic gnt_b
);

    // On a tie, favour whichever side was not granted last.
    assign gnt_b = req_b && (force_b || !req_a || !last_b);
    assign gnt_a = req_a && !gnt_b;

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Arbitrates the single-port CHIP-8 RAM between ROM loader, CPU and video.
// Handshake: a requester holds req/addr/we/wdata stable until it sees its gnt high;
// gnt is combinational, the access is issued on the following edge and read data
// comes back with the matching *_rvalid two cycles after gnt.
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int ADDR_W       = CHIP8_ADDR_W,
    parameter int DATA_W       = CHIP8_DATA_W,
    parameter int VID_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ld_rvalid,
    output logic              cpu_rvalid,
    output logic              vid_rvalid,
    output arb_state_e        dbg_state
);

    arb_state_e state_q, state_d;
    logic       last_vid_q;
    logic [7:0] vid_wait_q, vid_wait_d;
    logic       vid_force, cpu_cand, vid_cand;
    logic       rd_pend_q;
    req_idx_e   rd_owner_q;

    // A starved video request overrides both round-robin and the CPU lock.
    assign vid_force = vid_req && (vid_wait_q == 8'(VID_MAX_WAIT));
    assign cpu_cand  = cpu_req && !ld_req;
    assign vid_cand  = vid_req && !ld_req && (state_q == ARB || !cpu_req || vid_force);

    chip8_rr_pick2 u_pick (
        .req_a  (cpu_cand),
        .req_b  (vid_cand),
        .force_b(vid_force),
        .last_b (last_vid_q),
        .gnt_a  (cpu_gnt),
        .gnt_b  (vid_gnt)
    );

    assign ld_gnt    = ld_req;
    assign rdata     = mem_rdata;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        vid_wait_d = vid_wait_q;
        case (state_q)
            ARB:     if (cpu_gnt && cpu_lock) state_d = LOCKED;
            LOCKED:  if (!cpu_req || (cpu_gnt && !cpu_lock)) state_d = ARB;
            default: state_d = ARB;
        endcase
        if (!vid_req || vid_gnt) begin
            vid_wait_d = 8'd0;
        end else if (vid_wait_q != 8'(VID_MAX_WAIT)) begin
            vid_wait_d = vid_wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            last_vid_q <= 1'b1;
            vid_wait_q <= 8'd0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_LD;
            ld_rvalid  <= 1'b0;
            cpu_rvalid <= 1'b0;
            vid_rvalid <= 1'b0;
        end else begin
            state_q    <= state_d;
            vid_wait_q <= vid_wait_d;
            if (cpu_gnt || vid_gnt) last_vid_q <= vid_gnt;

            mem_we    <= 1'b0;
            rd_pend_q <= 1'b0;
            if (ld_gnt) begin
                mem_addr   <= ld_addr;
                mem_we     <= ld_we;
                mem_wdata  <= ld_wdata;
                rd_pend_q  <= !ld_we;
                rd_owner_q <= REQ_LD;
            end else if (cpu_gnt) begin
                mem_addr   <= cpu_addr;
                mem_we     <= cpu_we;
                mem_wdata  <= cpu_wdata;
                rd_pend_q  <= !cpu_we;
                rd_owner_q <= REQ_CPU;
            end else if (vid_gnt) begin
                mem_addr   <= vid_addr;
                rd_pend_q  <= 1'b1;
                rd_owner_q <= REQ_VID;
            end

            // RAM answers one cycle after the registered address.
            ld_rvalid  <= rd_pend_q && (rd_owner_q == REQ_LD);
            cpu_rvalid <= rd_pend_q && (rd_owner_q == REQ_CPU);
            vid_rvalid <= rd_pend_q && (rd_owner_q == REQ_VID);
        end
    end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a write-first synchronous RAM model.
module tb_chip8_mem_arbiter;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req, ld_we, cpu_req, cpu_we, cpu_lock, vid_req;
    logic [11:0] ld_addr, cpu_addr, vid_addr, mem_addr;
    logic [7:0]  ld_wdata, cpu_wdata, mem_wdata, mem_rdata, rdata;
    logic        ld_gnt, cpu_gnt, vid_gnt, mem_we;
    logic        ld_rvalid, cpu_rvalid, vid_rvalid;
    arb_state_e  dbg_state;
    logic [7:0]  ram [0:4095];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .VID_MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rdata(rdata), .ld_rvalid(ld_rvalid), .cpu_rvalid(cpu_rvalid), .vid_rvalid(vid_rvalid),
        .dbg_state(dbg_state)
    );

    // Write-first RAM; known contents are seeded while reset is high.
    always @(posedge clk) begin
        if (reset) begin
            ram[12'h300] <= 8'h5C;
            ram[12'h100] <= 8'h3E;
        end
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
        end else begin
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        ld_req = 0; ld_we = 0; ld_addr = 12'h000; ld_wdata = 8'h00;
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
        vid_req = 0; vid_addr = 12'h000;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        repeat (2) step();
        #1;
        chk("rst_state", 32'(dbg_state), 32'(ARB));
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rvalid", 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), 32'h0);
        reset = 1'b0;

        // Loader write beats a CPU read of the same address.
        step();
        ld_req = 1; ld_we = 1; ld_addr = 12'h200; ld_wdata = 8'hA2;
        cpu_req = 1; cpu_addr = 12'h200;
        #1;
        chk("ld_gnt", 32'(ld_gnt), 32'h1);
        chk("ld_cpu_blocked", 32'(cpu_gnt), 32'h0);
        step();
        ld_req = 0; ld_we = 0;
        #1;
        chk("ld_mem_we", 32'(mem_we), 32'h1);
        chk("ld_mem_addr", 32'(mem_addr), 32'h200);
        chk("ld_mem_wdata", 32'(mem_wdata), 32'hA2);
        chk("cpu_after_ld", 32'(cpu_gnt), 32'h1);
        step();
        cpu_req = 0;
        #1;
        chk("cpu_rd_mem_we", 32'(mem_we), 32'h0);
        chk("cpu_rd_mem_addr", 32'(mem_addr), 32'h200);
        chk("ld_write_no_rvalid", 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), 32'h0);
        step();
        #1;
        chk("wf_rvalid", 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), 32'b010);
        chk("wf_rdata", 32'(rdata), 32'hA2);

        // Plain CPU read of 0x300.
        step();
        cpu_req = 1; cpu_addr = 12'h300;
        #1;
        chk("cpu_rd_gnt", 32'(cpu_gnt), 32'h1);
        step();
        cpu_req = 0;
        #1;
        chk("cpu_rd_addr", 32'(mem_addr), 32'h300);
        chk("cpu_rd_pending", 32'(cpu_rvalid), 32'h0);
        step();
        #1;
        chk("cpu_rd_rvalid", 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), 32'b010);
        chk("cpu_rd_rdata", 32'(rdata), 32'h5C);

        // Video-only read of 0x100.
        step();
        vid_req = 1; vid_addr = 12'h100;
        #1;
        chk("vid_gnt", 32'({cpu_gnt, vid_gnt}), 32'b01);
        step();
        vid_req = 0;
        #1;
        chk("vid_mem_addr", 32'(mem_addr), 32'h100);
        step();
        #1;
        chk("vid_rvalid", 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), 32'b001);
        chk("vid_rdata", 32'(rdata), 32'h3E);

        // Round-robin with both held: CPU, VID, CPU, VID, CPU, VID.
        for (int i = 0; i < 6; i++) begin
            step();
            cpu_req = 1; cpu_addr = 12'h300; vid_req = 1; vid_addr = 12'h100;
            #1;
            chk($sformatf("rr_%0d", i), 32'({cpu_gnt, vid_gnt}), (i % 2 == 0) ? 32'b10 : 32'b01);
        end
        step();
        set_idle();
        #1;
        chk("rr_cpu_rvalid", 32'({cpu_rvalid, vid_rvalid}), 32'b10);
        chk("rr_cpu_rdata", 32'(rdata), 32'h5C);
        step();
        #1;
        chk("rr_vid_rvalid", 32'({cpu_rvalid, vid_rvalid}), 32'b01);
        chk("rr_vid_rdata", 32'(rdata), 32'h3E);

        // Locked two-byte fetch keeps video out for one extra cycle.
        step();
        cpu_req = 1; cpu_lock = 1; cpu_addr = 12'h200; vid_req = 1; vid_addr = 12'h100;
        #1;
        chk("lock_fetch0", 32'({cpu_gnt, vid_gnt}), 32'b10);
        step();
        cpu_lock = 0; cpu_addr = 12'h201;
        #1;
        chk("lock_state", 32'(dbg_state), 32'(LOCKED));
        chk("lock_fetch1", 32'({cpu_gnt, vid_gnt}), 32'b10);
        step();
        cpu_req = 0;
        #1;
        chk("lock_released", 32'(dbg_state), 32'(ARB));
        chk("lock_vid_third", 32'({cpu_gnt, vid_gnt}), 32'b01);
        step();
        set_idle();

        // Starvation: lock held, video forced through on the 5th cycle.
        step();
        cpu_req = 1; cpu_lock = 1; cpu_addr = 12'h300; vid_req = 1; vid_addr = 12'h100;
        #1;
        chk("idle_hold_addr", 32'(mem_addr), 32'h100);
        chk("idle_mem_we", 32'(mem_we), 32'h0);
        chk("lock_vid_rvalid", 32'({cpu_rvalid, vid_rvalid}), 32'b01);
        chk("starve_0", 32'({cpu_gnt, vid_gnt}), 32'b10);
        for (int i = 1; i < 6; i++) begin
            step();
            #1;
            chk($sformatf("starve_state_%0d", i), 32'(dbg_state), 32'(LOCKED));
            chk($sformatf("starve_%0d", i), 32'({cpu_gnt, vid_gnt}), (i == 4) ? 32'b01 : 32'b10);
        end

        // Loader preempts while locked; lock survives.
        step();
        ld_req = 1; ld_we = 1; ld_addr = 12'h400; ld_wdata = 8'h77;
        #1;
        chk("lock_ld_gnt", 32'({ld_gnt, cpu_gnt, vid_gnt}), 32'b100);
        step();
        ld_req = 0; ld_we = 0;
        #1;
        chk("lock_ld_state", 32'(dbg_state), 32'(LOCKED));
        chk("lock_ld_mem", 32'({mem_we, mem_addr, mem_wdata}), {11'b0, 1'b1, 12'h400, 8'h77});
        chk("lock_ld_cpu_gnt", 32'(cpu_gnt), 32'h1);

        // Reset one cycle after a CPU read grant.
        step();
        reset = 1; cpu_req = 0; vid_req = 0;
        step();
        reset = 0;
        #1;
        chk("rst_mid_rvalid", 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), 32'h0);
        chk("rst_mid_mem", 32'({mem_we, mem_addr, mem_wdata}), 32'h0);
        chk("rst_mid_state", 32'(dbg_state), 32'(ARB));
        step();
        cpu_req = 1; cpu_lock = 0; vid_req = 1;
        #1;
        chk("rst_rr_cpu_first", 32'({cpu_gnt, vid_gnt}), 32'b10);
        step();
        #1;
        chk("rst_rr_vid_next", 32'({cpu_gnt, vid_gnt}), 32'b01);
        step();
        set_idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
